led_chaser: RTL



---
 rtl/led_chaser.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/led_chaser.sv
// -----------------------------------------------------------------------------
// led_chaser
//
// Moves a single lit LED across a bank of NUM_LEDS outputs. A programmable
// prescaler produces a one-cycle enable tick (no derived clocks). Each tick,
// or a manual step pulse, advances the light according to the selected mode:
// bounce, rotate left, rotate right or hold.
//
// Ports:
//   clock_i   system clock
//   reset_i   synchronous, active-high reset
//   enable_i  prescaler run enable (counter holds and no ticks when low)
//   mode_i    00 bounce, 01 rotate left, 10 rotate right, 11 hold
//   period_i  tick every period_i+1 enabled cycles
//   step_i    manual advance, sampled every cycle
//   leds_o    registered one-hot LED drive
//   dir_o     current direction: 0 = toward MSB, 1 = toward LSB
//   tick_o    registered one-cycle prescaler pulse
//   wrap_o    registered one-cycle pulse on a bounce turn or rotate wrap
// -----------------------------------------------------------------------------
module led_chaser #(
    parameter int NUM_LEDS  = 26,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [1:0]           mode_i,
    input  logic [DIV_WIDTH-1:0] period_i,
    input  logic                 step_i,
    output logic [NUM_LEDS-1:0]  leds_o,
    output logic                 dir_o,
    output logic                 tick_o,
    output logic                 wrap_o
);

    localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        MODE_BOUNCE    = 2'b00,
        MODE_ROT_LEFT  = 2'b01,
        MODE_ROT_RIGHT = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_t;

    mode_t                mode;
    logic [DIV_WIDTH-1:0] count;
    logic [POS_W-1:0]     pos;
    logic [POS_W-1:0]     pos_next;
    logic                 dir_next;
    logic                 wrap_next;
    logic                 adv;

    assign mode = mode_t'(mode_i);

    // A tick and a coincident step collapse into a single advance.
    assign adv = tick_o | step_i;

    // Prescaler. The >= compare means shrinking period_i below the current
    // count fires on the next edge instead of waiting for a full wrap.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count  <= '0;
            tick_o <= 1'b0;
        end else if (enable_i && (count >= period_i)) begin
            count  <= '0;
            tick_o <= 1'b1;
        end else if (enable_i) begin
            count  <= count + DIV_WIDTH'(1);
            tick_o <= 1'b0;
        end else begin
            tick_o <= 1'b0;
        end
    end

    // Next position/direction. A single-LED bank never moves, turns or
    // wraps, so the whole update is gated off in that case.
    always_comb begin
        pos_next  = pos;
        dir_next  = dir_o;
        wrap_next = 1'b0;
        if (adv && (NUM_LEDS > 1)) begin
            case (mode)
                MODE_BOUNCE: begin
                    if (!dir_o) begin
                        if (pos == LAST_POS) begin
                            dir_next  = 1'b1;
                            pos_next  = pos - POS_W'(1);
                            wrap_next = 1'b1;
                        end else begin
                            pos_next = pos + POS_W'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_next  = 1'b0;
                            pos_next  = POS_W'(1);
                            wrap_next = 1'b1;
                        end else begin
                            pos_next = pos - POS_W'(1);
                        end
                    end
                end
                MODE_ROT_LEFT: begin
                    dir_next = 1'b0;
                    if (pos == LAST_POS) begin
                        pos_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        pos_next = pos + POS_W'(1);
                    end
                end
                MODE_ROT_RIGHT: begin
                    dir_next = 1'b1;
                    if (pos == '0) begin
                        pos_next  = LAST_POS;
                        wrap_next = 1'b1;
                    end else begin
                        pos_next = pos - POS_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // leds_o is decoded from the next position so it stays in lockstep
    // with pos while still being a plain register on the output.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pos    <= '0;
            dir_o  <= 1'b0;
            wrap_o <= 1'b0;
            leds_o <= NUM_LEDS'(1);
        end else begin
            pos    <= pos_next;
            dir_o  <= dir_next;
            wrap_o <= wrap_next;
            leds_o <= NUM_LEDS'(1) << pos_next;
        end
    end

endmodule
